// File: rtl/pistorm_pkg.sv
// ---------------------------------------------------------------------------
// pistorm_pkg
// Shared definitions for the Amiga-side 68000 bus responder:
//   - SYNC_STAGES   depth of the control-signal synchroniser
//   - FC_CPU_SPACE  68000 function code for CPU space (interrupt ack etc.)
//   - ST_*          4-bit state encodings and the slave_state_e enum
// ---------------------------------------------------------------------------
package pistorm_pkg;

  localparam int         SYNC_STAGES  = 2;
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_DECODE      = 4'd1;
  localparam logic [3:0] ST_WAIT_DS     = 4'd2;
  localparam logic [3:0] ST_REQ         = 4'd3;
  localparam logic [3:0] ST_WAIT_RSP    = 4'd4;
  localparam logic [3:0] ST_SETUP       = 4'd5;
  localparam logic [3:0] ST_ACK         = 4'd6;
  localparam logic [3:0] ST_NEG         = 4'd7;
  localparam logic [3:0] ST_BERR        = 4'd8;
  localparam logic [3:0] ST_WAIT_AS_REL = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE        = ST_IDLE,
    S_DECODE      = ST_DECODE,
    S_WAIT_DS     = ST_WAIT_DS,
    S_REQ         = ST_REQ,
    S_WAIT_RSP    = ST_WAIT_RSP,
    S_SETUP       = ST_SETUP,
    S_ACK         = ST_ACK,
    S_NEG         = ST_NEG,
    S_BERR        = ST_BERR,
    S_WAIT_AS_REL = ST_WAIT_AS_REL
  } slave_state_e;

endpackage

// File: rtl/bus_input_sync.sv
// ---------------------------------------------------------------------------
// bus_input_sync
// Multi-flop synchroniser for a group of asynchronous 68000 bus control
// signals. Each bit is synchronised independently; depth is SYNC_STAGES.
// Ports:
//   clk       in   sampling clock
//   rst_n     in   synchronous active-low reset (loads RESET_VAL)
//   async_in  in   WIDTH raw asynchronous inputs
//   sync_out  out  WIDTH synchronised outputs
// ---------------------------------------------------------------------------
module bus_input_sync
  import pistorm_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  (* async_reg = "true" *) logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_slave_port.sv
// ---------------------------------------------------------------------------
// m68k_slave_port
// Amiga-side 68000 bus responder. Decodes bus cycles that fall inside a
// 2**WIN_BITS byte window at BASE_ADDR (excluding CPU space), forwards each
// as a single-word request to the Pi-side register logic, drives read data
// back and terminates with nDTACK (or nBERR after TIMEOUT cycles).
// Ports:
//   sys_clk, nRESET              sole clock, synchronous active-low reset
//   nAS_IN/nUDS_IN/nLDS_IN       raw strobes (synchronised internally)
//   RnW_IN, FC_IN                raw direction and function code (synchronised)
//   A_IN[23:1], D_IN             raw address/data, captured once stable
//   D_OUT, D_OE                  read data and per-bit drive enables
//   nDTACK_OUT, nDTACK_OE        DTACK level and drive enable
//   nBERR_OE                     open-drain BERR pull-low enable
//   req_*                        request toward Pi side (valid/ready handshake)
//   rsp_valid, rsp_rdata         completion pulse and read data from Pi side
//   busy                         FSM not idle
// All bus-facing outputs are registered from the next-state decode so the
// pins never glitch on state-encoding transitions.
// ---------------------------------------------------------------------------
module m68k_slave_port
  import pistorm_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'hE90000,
  parameter int          WIN_BITS    = 16,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int          DTACK_SETUP = 2
) (
  input  logic                sys_clk,
  input  logic                nRESET,
  input  logic                nAS_IN,
  input  logic                nUDS_IN,
  input  logic                nLDS_IN,
  input  logic                RnW_IN,
  input  logic [2:0]          FC_IN,
  input  logic [23:1]         A_IN,
  input  logic [15:0]         D_IN,
  output logic [15:0]         D_OUT,
  output logic [15:0]         D_OE,
  output logic                nDTACK_OUT,
  output logic                nDTACK_OE,
  output logic                nBERR_OE,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [1:0]          req_be,
  output logic [WIN_BITS-1:0] req_addr,
  output logic [15:0]         req_wdata,
  input  logic                rsp_valid,
  input  logic [15:0]         rsp_rdata,
  output logic                busy
);

  localparam logic [11:0] TIMEOUT_CNT = 12'(TIMEOUT);
  localparam logic [11:0] SETUP_LAST  = 12'(DTACK_SETUP - 1);

  // Control group: {as, uds, lds, rw, fc[2:0]}; idle values are strobes
  // negated and RnW high.
  logic [6:0] ctrl_raw;
  logic [6:0] ctrl_s;
  logic       as_s;
  logic       uds_s;
  logic       lds_s;
  logic       rw_s;
  logic [2:0] fc_s;

  assign ctrl_raw = {~nAS_IN, ~nUDS_IN, ~nLDS_IN, RnW_IN, FC_IN};

  bus_input_sync #(
    .WIDTH     (7),
    .RESET_VAL (7'b0001000)
  ) u_ctrl_sync (
    .clk      (sys_clk),
    .rst_n    (nRESET),
    .async_in (ctrl_raw),
    .sync_out (ctrl_s)
  );

  assign as_s  = ctrl_s[6];
  assign uds_s = ctrl_s[5];
  assign lds_s = ctrl_s[4];
  assign rw_s  = ctrl_s[3];
  assign fc_s  = ctrl_s[2:0];

  slave_state_e        state_q, state_d;
  logic [11:0]         cnt_q, cnt_d;
  logic                aborted_q, aborted_d;
  logic [WIN_BITS-1:1] addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         dout_q, dout_d;
  logic                d_oe_q, d_oe_d;
  logic                dtack_oe_q, dtack_oe_d;
  logic                dtack_n_q, dtack_n_d;
  logic                berr_oe_q, berr_oe_d;
  logic                req_valid_q, req_valid_d;
  logic                busy_q, busy_d;

  logic [11:0] cnt_inc;
  logic        timeout_hit;
  logic        addr_hit;
  logic        abort_now;

  // Saturating count: once past TIMEOUT the >= compare keeps firing, so a
  // request accepted exactly on the timeout cycle still times out later.
  assign cnt_inc     = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
  assign timeout_hit = (TIMEOUT_CNT != 12'd0) && (cnt_inc >= TIMEOUT_CNT);
  assign addr_hit    = (A_IN[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS]);
  assign abort_now   = aborted_q | ~as_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;

    unique case (state_q)
      S_IDLE: begin
        if (as_s) state_d = S_DECODE;
      end

      // as_s has been high for a cycle, so A_IN is settled here.
      S_DECODE: begin
        addr_d = A_IN[WIN_BITS-1:1];
        rw_d   = rw_s;
        if (!as_s)
          state_d = S_IDLE;
        else if (addr_hit && (fc_s != FC_CPU_SPACE))
          state_d = S_WAIT_DS;
        else
          state_d = S_WAIT_AS_REL;
      end

      S_WAIT_DS: begin
        if (!as_s) begin
          state_d = S_IDLE;
        end else if (uds_s || lds_s) begin
          be_d      = {uds_s, lds_s};
          wdata_d   = D_IN;
          cnt_d     = '0;
          aborted_d = 1'b0;
          state_d   = S_REQ;
        end
      end

      // Once the Pi side accepts the request it always gets to complete;
      // an AS drop only suppresses the DTACK.  If it never answers an
      // aborted cycle, the timeout returns quietly to IDLE rather than
      // pulling BERR onto somebody else's bus cycle.
      S_REQ, S_WAIT_RSP: begin
        cnt_d = cnt_inc;
        if (!as_s) aborted_d = 1'b1;
        if ((state_q == S_REQ) && !req_ready) begin
          if (timeout_hit) state_d = abort_now ? S_IDLE : S_BERR;
        end else if (rsp_valid) begin
          if (abort_now) begin
            state_d = S_IDLE;
          end else if (rw_q) begin
            dout_d  = rsp_rdata;
            cnt_d   = '0;
            state_d = S_SETUP;
          end else begin
            state_d = S_ACK;
          end
        end else if (state_q == S_REQ) begin
          state_d = S_WAIT_RSP;
        end else if (timeout_hit) begin
          state_d = abort_now ? S_IDLE : S_BERR;
        end
      end

      S_SETUP: begin
        cnt_d = cnt_inc;
        if (cnt_q >= SETUP_LAST) state_d = S_ACK;
      end

      S_ACK: begin
        if (!as_s) state_d = S_NEG;
      end

      S_NEG: begin
        state_d = S_IDLE;
      end

      S_BERR: begin
        if (!as_s) state_d = S_IDLE;
      end

      S_WAIT_AS_REL: begin
        if (!as_s) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so pins change together with state_q.
  always_comb begin
    d_oe_d      = rw_d && ((state_d == S_SETUP) || (state_d == S_ACK));
    dtack_oe_d  = (state_d == S_ACK) || (state_d == S_NEG);
    dtack_n_d   = (state_d != S_ACK);
    berr_oe_d   = (state_d == S_BERR);
    req_valid_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      aborted_q   <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      be_q        <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
      d_oe_q      <= 1'b0;
      dtack_oe_q  <= 1'b0;
      dtack_n_q   <= 1'b1;
      berr_oe_q   <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aborted_q   <= aborted_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      dout_q      <= dout_d;
      d_oe_q      <= d_oe_d;
      dtack_oe_q  <= dtack_oe_d;
      dtack_n_q   <= dtack_n_d;
      berr_oe_q   <= berr_oe_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign D_OUT      = dout_q;
  assign D_OE       = {16{d_oe_q}};
  assign nDTACK_OUT = dtack_n_q;
  assign nDTACK_OE  = dtack_oe_q;
  assign nBERR_OE   = berr_oe_q;
  assign req_valid  = req_valid_q;
  assign req_write  = ~rw_q;
  assign req_be     = be_q;
  assign req_addr   = {addr_q, 1'b0};
  assign req_wdata  = wdata_q;
  assign busy       = busy_q;

endmodule
